// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus bundle.
// Handshake: the sequencer raises ir_valid while ir holds an instruction and
// waits for exec_done. A clock edge with ir_valid=1 and exec_done=1 completes
// the instruction. pc_en is a one-cycle strobe and pc_in is valid while it is
// high. exec_done is ignored while ir_valid=0.
interface fetch_ctrl_if;
  logic [15:0] pc_count;
  logic [15:0] mem_rdata;
  logic [4:0]  flags;
  logic [15:0] rtarget_data;
  logic        exec_done;
  logic        hold;
  logic [15:0] mem_addr;
  logic [15:0] ir;
  logic        ir_valid;
  logic        pc_en;
  logic [15:0] pc_in;
  logic        branch_taken;

  // Sequencer side
  modport master (
    input  pc_count, mem_rdata, flags, rtarget_data, exec_done, hold,
    output mem_addr, ir, ir_valid, pc_en, pc_in, branch_taken
  );

  // PC register / memory / datapath side
  modport slave (
    output pc_count, mem_rdata, flags, rtarget_data, exec_done, hold,
    input  mem_addr, ir, ir_valid, pc_en, pc_in, branch_taken
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: fetches the instruction at pc_count, holds it in ir for
// the datapath, then returns the sequential, branch or jump next PC to the
// PC register with a one-cycle pc_en strobe.
module fetch_ctrl #(
  parameter int          MEM_LAT  = 1,        // memory read latency, 1..3
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus,
  output logic [1:0]   state_o              // debug view of the FSM state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_EXEC  = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  // Counter preload so S_LOAD lasts exactly MEM_LAT cycles.
  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_t      state_q;
  logic [1:0]  wait_q;
  logic [15:0] ir_q;
  logic        ir_valid_q;
  logic        pc_en_q;
  logic [15:0] pc_in_q;
  logic        taken_q;

  logic        is_bcond;
  logic        is_jcond;
  logic        cond_hit;
  logic        redirect_d;
  logic [15:0] next_pc_d;
  logic        flag_n, flag_z, flag_f, flag_l, flag_c;

  assign {flag_n, flag_z, flag_f, flag_l, flag_c} = bus.flags;

  // Decode the held instruction and select the next PC.
  always_comb begin
    is_bcond = (ir_q[15:12] == 4'b1100);
    is_jcond = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b1100);
    cond_hit = 1'b0;
    case (ir_q[11:8])
      4'b0000: cond_hit = flag_z;
      4'b0001: cond_hit = !flag_z;
      4'b0010: cond_hit = flag_c;
      4'b0011: cond_hit = !flag_c;
      4'b0100: cond_hit = flag_l;
      4'b0101: cond_hit = !flag_l;
      4'b0110: cond_hit = flag_n;
      4'b0111: cond_hit = !flag_n;
      4'b1000: cond_hit = flag_f;
      4'b1001: cond_hit = !flag_f;
      4'b1010: cond_hit = !flag_l && !flag_z;
      4'b1011: cond_hit = flag_l || flag_z;
      4'b1100: cond_hit = !flag_n && !flag_z;
      4'b1101: cond_hit = flag_n || flag_z;
      4'b1110: cond_hit = 1'b1;
      default: cond_hit = 1'b0;
    endcase
    redirect_d = (is_bcond || is_jcond) && cond_hit;
    next_pc_d  = bus.pc_count + 16'd1;
    if (redirect_d && is_bcond) begin
      next_pc_d = bus.pc_count + {{8{ir_q[7]}}, ir_q[7:0]};
    end else if (redirect_d && is_jcond) begin
      next_pc_d = bus.rtarget_data;
    end
  end

  // Fetch/load/execute/next sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_q     <= 2'd0;
      ir_q       <= IR_RESET;
      ir_valid_q <= 1'b0;
      pc_en_q    <= 1'b0;
      pc_in_q    <= 16'h0000;
      taken_q    <= 1'b0;
    end else begin
      pc_en_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!bus.hold) begin
            wait_q  <= WAIT_INIT;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (wait_q != 2'd0) begin
            wait_q <= wait_q - 2'd1;
          end else begin
            ir_q       <= bus.mem_rdata;
            ir_valid_q <= 1'b1;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            pc_in_q    <= next_pc_d;
            taken_q    <= redirect_d;
            ir_valid_q <= 1'b0;
            pc_en_q    <= 1'b1;
            state_q    <= S_NEXT;
          end
        end
        S_NEXT: begin
          state_q <= S_FETCH;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.mem_addr     = bus.pc_count;
  assign bus.ir           = ir_q;
  assign bus.ir_valid     = ir_valid_q;
  assign bus.pc_en        = pc_en_q;
  assign bus.pc_in        = pc_in_q;
  assign bus.branch_taken = taken_q;
  assign state_o          = state_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that sits on the consuming side of the program counter register. It takes the registered PC value, drives instruction memory, latches the returned instruction and hands it to the datapath. It then computes the next PC and returns it to the PC register on pc_in, strobing pc_en. It owns all sequential, branch (Bcond) and jump (Jcond) next-PC selection.

Parameters:
MEM_LAT, 1, instruction-memory read latency in cycles (legal 1..3); the number of cycles spent in S_LOAD.
IR_RESET, 16'h0000, reset and abort value of ir.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
pc_count  in  16  current PC from the PC register
mem_rdata  in  16  instruction-memory read data
flags  in  5  {N,Z,F,L,C} from the datapath PSR
rtarget_data  in  16  register-file read of ir[3:0] (jump target)
exec_done  in  1  datapath has finished the instruction in ir
hold  in  1  freeze in S_FETCH (debug/stall)
mem_addr  out  16  instruction-memory address
ir  out  16  instruction register
ir_valid  out  1  ir holds an instruction for the datapath
pc_en  out  1  one-cycle load strobe to the PC register
pc_in  out  16  next PC value
branch_taken  out  1  registered: last completed instruction redirected the PC

Behaviour:
- Reset (async, any state): state=S_FETCH, ir=IR_RESET, ir_valid=0, pc_en=0, pc_in=0, branch_taken=0, wait counter=0. The PC register resets to 0 on the same rst, so the first fetch is address 0x0000.
- mem_addr = pc_count combinationally, in every state.
- S_FETCH: if hold=1, stay. Otherwise load wait counter=MEM_LAT-1 and go to S_LOAD.
- S_LOAD: while counter!=0, decrement. When counter==0, latch ir<=mem_rdata, set ir_valid<=1 and go to S_EXEC.
- S_EXEC: ir_valid=1 and ir stable. Wait for exec_done. When exec_done=1 on a clock edge:
  - register the next PC into pc_in.
  - register branch_taken.
  - clear ir_valid.
  - go to S_NEXT.
- If exec_done is already high on the first S_EXEC cycle, it is accepted in that cycle.
- S_NEXT: pc_en=1 for exactly this one cycle; pc_in is stable. Return to S_FETCH. pc_en=0 in all other states.
- Minimum cost is 3+MEM_LAT cycles per instruction (4 with MEM_LAT=1).
- hold is sampled only in S_FETCH. It does not affect an instruction already in flight.
- Decode, using ir at the exec_done edge:
  - Bcond: ir[15:12]=4'b1100. cond=ir[11:8]; disp=sign-extended ir[7:0].
  - Jcond: ir[15:12]=4'b0100 and ir[7:4]=4'b1100. cond=ir[11:8]; target=rtarget_data.
  - Every other encoding is sequential.
- Conditions, evaluated on flags sampled at the exec_done edge:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L&!Z
  - 1011 HS: L|Z
  - 1100 LT: !N&!Z
  - 1101 GE: N|Z
  - 1110 UC: 1
  - 1111: 0 (never)
- Next PC, all arithmetic 16-bit modulo 2^16, carry discarded:
  - Taken Bcond: pc_count + disp.
  - Taken Jcond: rtarget_data.
  - Otherwise: pc_count + 1.
- branch_taken = taken Bcond or taken Jcond. It holds until the next exec_done edge.
- Wrap-around:
  - 0xFFFF + 1 gives 0x0000.
  - 0x0002 + disp 0x80 (-128) gives 0xFF82.
- Reset asserted in any state aborts the instruction: no pc_en pulse, ir returns to IR_RESET.
- exec_done outside S_EXEC is ignored.

Test Plan:
- MEM_LAT=1, memory[0..2] = non-branch, exec_done tied 1. Required: pc_en pulses every 4 cycles; pc_in = 0x0001, 0x0002, 0x0003; ir matches memory each time; branch_taken=0.
- Bcond cond=0000 (EQ), disp=0xFE, at PC 0x0010 with Z=1. Required: pc_in=0x000E, branch_taken=1. Repeat with Z=0: pc_in=0x0011, branch_taken=0.
- Jcond UC with rtarget_data=0xABCD. Required: pc_in=0xABCD. Cond=1111 with the same target: pc_in = pc_count + 1.
- pc_count=0xFFFF, non-branch. Required: pc_in=0x0000. Bcond UC at 0x0002 with disp 0x80: pc_in=0xFF82.
- Hold exec_done=0 for 10 cycles in S_EXEC. Required: ir_valid stays 1, ir is stable, pc_en stays 0. Assert rst mid-S_EXEC: immediately ir=0x0000, ir_valid=0, no pc_en pulse; after release the next fetch is at address 0x0000.
- MEM_LAT=3. Required: ir captured 3 cycles after leaving S_FETCH. hold=1 in S_FETCH for 5 cycles: no state advance and no pc_en, and mem_addr tracks pc_count throughout.
